pwm_multi: RTL and testbench

Multi-channel, parametrised PWM generator: the next generation of the team's single-channel 8-bit and percent PWM blocks. All channels share one programmable-period counter. Each channel has its own duty value. Duty, period and alignment mode (edge or center) are double-buffered, so a new configuration takes effect only at a period boundary and never produces a glitch mid-period. The block sits between a register/control interface and LED, motor or driver pins.

---
 rtl/pwm_multi.sv | 131 +++++++++++++
 tb/tb_pwm_multi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
`timescale 1ns/1ps
// pwm_multi: multi-channel PWM, shared programmable-period counter, per-channel duty,
//            edge/center alignment, double-buffered configuration applied at period boundaries.
// Latency: sig_out/sync are registered, lagging the counter state by one cycle; new config shows
//          on sig_out one cycle after the boundary that applies it. No backpressure (load always accepted).
// Ports: clk, rst (sync active-high), en, load, period_in[W], duty_in[CH*W] (channel i at [i*W +: W]),
//        center_in, [pol[CH] when PWM_MULTI_POLARITY_EN is defined], sig_out[CH], sync, pending.
module pwm_multi #(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [W-1:0]    period_in,
    input  logic [CH*W-1:0] duty_in,
    input  logic            center_in,
`ifdef PWM_MULTI_POLARITY_EN
    input  logic [CH-1:0]   pol,
`endif
    output logic [CH-1:0]   sig_out,
    output logic            sync,
    output logic            pending
);

    // Staging (s_*) and active (a_*) register sets
    logic [W-1:0]    s_period, a_period;
    logic [CH*W-1:0] s_duty,   a_duty;
    logic            s_center, a_center;

    logic [W-1:0]    cnt;
    logic            dn;

    logic [CH-1:0]   cmp;
    logic [CH-1:0]   act_pol;
    logic            boundary;
    logic            first;

`ifdef PWM_MULTI_POLARITY_EN
    logic [CH-1:0]   s_pol, a_pol;
    assign act_pol = a_pol;
`else
    assign act_pol = '0;
`endif

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CH; i++) begin
            cmp[i] = (cnt < a_duty[i*W +: W]);
        end
        // P=0 degenerates to a boundary on every cycle in both modes.
        // In center mode the counter visits 0 twice per period; only the
        // down-going visit ends the period.
        if (a_period == '0)
            boundary = 1'b1;
        else if (a_center)
            boundary = dn && (cnt == '0);
        else
            boundary = (cnt == a_period);
        // The only state with cnt==0 going up is the first cycle of a period.
        first = (cnt == '0) && !dn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_period <= '1;
            a_period <= '1;
            s_duty   <= '0;
            a_duty   <= '0;
            s_center <= 1'b0;
            a_center <= 1'b0;
`ifdef PWM_MULTI_POLARITY_EN
            s_pol    <= '0;
            a_pol    <= '0;
`endif
            pending  <= 1'b0;
            cnt      <= '0;
            dn       <= 1'b0;
            sig_out  <= '0;
            sync     <= 1'b0;
        end else begin
            if (load) begin
                s_period <= period_in;
                s_duty   <= duty_in;
                s_center <= center_in;
`ifdef PWM_MULTI_POLARITY_EN
                s_pol    <= pol;
`endif
            end

            // Transfer uses S from before this cycle's load; a coincident
            // load keeps pending set for the following boundary.
            if (pending && (!en || boundary)) begin
                a_period <= s_period;
                a_duty   <= s_duty;
                a_center <= s_center;
`ifdef PWM_MULTI_POLARITY_EN
                a_pol    <= s_pol;
`endif
            end
            pending <= load || (pending && en && !boundary);

            if (!en) begin
                cnt     <= '0;
                dn      <= 1'b0;
                sig_out <= act_pol;
                sync    <= 1'b0;
            end else begin
                sig_out <= cmp ^ act_pol;
                sync    <= first;
                if (boundary) begin
                    cnt <= '0;
                    dn  <= 1'b0;
                end else if (!a_center) begin
                    cnt <= cnt + W'(1);
                end else if (!dn) begin
                    // Turn-around: P-1 is held for one extra cycle by
                    // flipping direction without moving the counter.
                    if (cnt == a_period - W'(1))
                        dn <= 1'b1;
                    else
                        cnt <= cnt + W'(1);
                end else begin
                    cnt <= cnt - W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
`timescale 1ns/1ps
// tb_pwm_multi: directed scoreboard bench for pwm_multi (CH=4, W=8).
// Expected per-cycle {sync, sig_out} vectors are derived from period/duty formulas,
// queued ahead of time and popped on each sampled output cycle (negedge sampling).
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            load;
    logic [W-1:0]    period_in;
    logic [CH*W-1:0] duty_in;
    logic            center_in;
    logic [CH-1:0]   sig_out;
    logic            sync;
    logic            pending;

    int n_assert = 0;
    int n_fail   = 0;

    logic [CH:0] exp_q[$];

    pwm_multi #(.CH(CH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .period_in (period_in),
        .duty_in   (duty_in),
        .center_in (center_in),
        .sig_out   (sig_out),
        .sync      (sync),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge mode: cycle k of a (P+1)-cycle period is high iff k < D.
    task automatic push_edge(input int p, input logic [31:0] d, input int n);
        logic [CH:0] e;
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k <= p; k++) begin
                e[CH] = (k == 0);
                for (int c = 0; c < CH; c++) e[c] = (k < int'(d[c*W +: W]));
                exp_q.push_back(e);
            end
        end
    endtask

    // Center mode: counter value at cycle k of a 2P-cycle period is k going
    // up, then 2P-1-k coming down; high iff that value < D.
    task automatic push_center(input int p, input logic [31:0] d, input int n);
        logic [CH:0] e;
        int cv;
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < 2 * p; k++) begin
                cv = (k < p) ? k : (2 * p - 1 - k);
                e[CH] = (k == 0);
                for (int c = 0; c < CH; c++) e[c] = (cv < int'(d[c*W +: W]));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step_cmp(input string tag);
        logic [CH:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_underflow"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sig"},  32'(sig_out), 32'(e[CH-1:0]));
            chk({tag, "_sync"}, 32'(sync),    32'(e[CH]));
        end
    endtask

    task automatic wait_sync(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sync === 1'b1) break;
        end
        chk({tag, "_wait_sync"}, 32'(sync), 32'd1);
    endtask

    task automatic wait_pending_clear(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (pending === 1'b0) break;
        end
        chk({tag, "_pending_clear"}, 32'(pending), 32'd0);
    endtask

    task automatic do_load(input int p, input logic [31:0] d, input logic c);
        period_in = W'(p);
        duty_in   = d;
        center_in = c;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0;
        period_in = '0; duty_in = '0; center_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sig", 32'(sig_out), 32'd0);
        chk("reset_sync", 32'(sync), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_period", 32'(dut.a_period), 32'd255);
        rst = 1'b0;
        @(negedge clk);

        // 1: edge, P=9, D={0,3,10,200}; loaded while disabled
        do_load(9, {8'd200, 8'd10, 8'd3, 8'd0}, 1'b0);
        chk("s1_pending_set", 32'(pending), 32'd1);
        @(negedge clk);
        chk("s1_pending_en0_xfer", 32'(pending), 32'd0);
        chk("s1_active_period", 32'(dut.a_period), 32'd9);
        en = 1'b1;
        push_edge(9, {8'd200, 8'd10, 8'd3, 8'd0}, 3);
        wait_sync("s1", 40);
        for (int i = 0; i < 30; i++) begin
            step_cmp("s1");
            @(negedge clk);
        end
        chk("s1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: center, P=8, D=3 on all channels
        do_load(8, {4{8'd3}}, 1'b1);
        wait_pending_clear("s2", 40);
        push_center(8, {4{8'd3}}, 2);
        wait_sync("s2", 40);
        for (int i = 0; i < 32; i++) begin
            step_cmp("s2");
            @(negedge clk);
        end
        chk("s2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: edge P=9 D=2, mid-period load of D=5
        do_load(9, {4{8'd2}}, 1'b0);
        wait_pending_clear("s3", 40);
        push_edge(9, {4{8'd2}}, 1);
        push_edge(9, {4{8'd5}}, 2);
        wait_sync("s3", 40);
        for (int i = 0; i < 30; i++) begin
            step_cmp("s3");
            if (i == 4) chk("s3_pending_before", 32'(pending), 32'd0);
            if (i >= 5 && i <= 8) chk("s3_pending_held", 32'(pending), 32'd1);
            if (i == 9) chk("s3_pending_cleared", 32'(pending), 32'd0);
            load = (i == 4);
            if (i == 4) begin
                period_in = 8'd9; duty_in = {4{8'd5}}; center_in = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk("s3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: load D=7 mid-period, then D=1 exactly on the boundary cycle
        push_edge(9, {4{8'd5}}, 1);
        push_edge(9, {4{8'd7}}, 1);
        push_edge(9, {4{8'd1}}, 2);
        for (int i = 0; i < 40; i++) begin
            step_cmp("s4");
            if (i == 9)  chk("s4_pending_kept", 32'(pending), 32'd1);
            if (i == 19) chk("s4_pending_final", 32'(pending), 32'd0);
            load = (i == 2) || (i == 8);
            if (i == 2) duty_in = {4{8'd7}};
            if (i == 8) duty_in = {4{8'd1}};
            @(negedge clk);
        end
        load = 1'b0;
        chk("s4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: P=0 with D={1,0,1,0}, then en=0 and restart
        do_load(0, {8'd0, 8'd1, 8'd0, 8'd1}, 1'b0);
        wait_pending_clear("s5", 40);
        push_edge(0, {8'd0, 8'd1, 8'd0, 8'd1}, 6);
        wait_sync("s5", 40);
        for (int i = 0; i < 6; i++) begin
            step_cmp("s5");
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        chk("s5_dis_sig", 32'(sig_out), 32'd0);
        chk("s5_dis_sync", 32'(sync), 32'd0);
        chk("s5_dis_cnt", 32'(dut.cnt), 32'd0);
        @(negedge clk);
        chk("s5_dis_sig2", 32'(sig_out), 32'd0);
        en = 1'b1;
        push_edge(0, {8'd0, 8'd1, 8'd0, 8'd1}, 4);
        wait_sync("s5_restart", 5);
        for (int i = 0; i < 4; i++) begin
            step_cmp("s5_restart");
            @(negedge clk);
        end
        chk("s5_q_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset mid-period with a staged load outstanding
        do_load(9, {4{8'd6}}, 1'b0);
        wait_pending_clear("s6", 40);
        wait_sync("s6", 40);
        repeat (3) @(negedge clk);
        do_load(50, {4{8'd9}}, 1'b1);
        chk("s6_pending_staged", 32'(pending), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_sig", 32'(sig_out), 32'd0);
        chk("s6_rst_sync", 32'(sync), 32'd0);
        chk("s6_rst_pending", 32'(pending), 32'd0);
        chk("s6_rst_period", 32'(dut.a_period), 32'd255);
        chk("s6_rst_duty", dut.a_duty, 32'd0);
        chk("s6_rst_cnt", 32'(dut.cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        push_edge(255, 32'd0, 1);
        for (int i = 0; i < 256; i++) begin
            step_cmp("s6_after_rst");
            @(negedge clk);
        end
        chk("s6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
